// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for a single-port RAM.
// A transaction takes three cycles: grant in IDLE, RAM access in SERVE, ack in ACK.
module ram_arbiter #(
    parameter int unsigned MEMSIZE     = 16,
    parameter int unsigned ADDRESSSIZE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   we0,
    input  logic                   we1,
    input  logic [ADDRESSSIZE-1:0] addr0,
    input  logic [ADDRESSSIZE-1:0] addr1,
    input  logic [MEMSIZE-1:0]     wdata0,
    input  logic [MEMSIZE-1:0]     wdata1,
    output logic                   ack0,
    output logic                   ack1,
    output logic [MEMSIZE-1:0]     rdata0,
    output logic [MEMSIZE-1:0]     rdata1,
    output logic                   busy,
    output logic [ADDRESSSIZE-1:0] ram_address,
    output logic [MEMSIZE-1:0]     ram_write_data,
    output logic                   ram_en_write,
    output logic                   ram_en_read,
    input  logic [MEMSIZE-1:0]     ram_read_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SERVE = 2'd1;
    localparam logic [1:0] ACK   = 2'd2;

    logic [1:0]             state;
    logic [1:0]             next_state;
    logic                   rr;
    logic                   lat_id;
    logic                   lat_we;
    logic                   grant_c;
    logic                   grant_id_c;
    logic                   sel_we_c;
    logic [ADDRESSSIZE-1:0] sel_addr_c;
    logic [MEMSIZE-1:0]     sel_wdata_c;

    // Next-state and grant decision; requests are only looked at in IDLE
    always_comb begin
        next_state = state;
        grant_c    = 1'b0;
        grant_id_c = rr;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant_c    = 1'b1;
                    grant_id_c = (req0 && req1) ? rr : req1;
                    next_state = SERVE;
                end
            end
            SERVE:   next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Select the granted requester's transaction fields
    always_comb begin
        sel_we_c    = grant_id_c ? we1    : we0;
        sel_addr_c  = grant_id_c ? addr1  : addr0;
        sel_wdata_c = grant_id_c ? wdata1 : wdata0;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Transaction latch, RAM pins, read capture, acks and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr             <= 1'b0;
            lat_id         <= 1'b0;
            lat_we         <= 1'b0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            busy           <= 1'b0;
            ram_address    <= '0;
            ram_write_data <= '0;
            ram_en_write   <= 1'b0;
            ram_en_read    <= 1'b0;
        end else begin
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            ram_en_write <= 1'b0;
            ram_en_read  <= 1'b0;
            busy         <= (next_state != IDLE);

            // Address/data stay put after SERVE so the RAM pins only move on a grant
            if (grant_c) begin
                lat_id         <= grant_id_c;
                lat_we         <= sel_we_c;
                ram_address    <= sel_addr_c;
                ram_write_data <= sel_wdata_c;
                ram_en_write   <= sel_we_c;
                ram_en_read    <= !sel_we_c;
            end

            if (state == SERVE) begin
                if (!lat_we) begin
                    if (lat_id) begin
                        rdata1 <= ram_read_data;
                    end else begin
                        rdata0 <= ram_read_data;
                    end
                end
                ack0 <= !lat_id;
                ack1 <= lat_id;
            end

            if (state == ACK) begin
                rr <= !lat_id;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, transaction-level scoreboard, directed scenarios.
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [3:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, busy;
    logic [15:0] rdata0, rdata1;
    logic [3:0]  ram_address;
    logic [15:0] ram_write_data;
    logic        ram_en_write, ram_en_read;
    logic [15:0] ram_read_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ram_arbiter #(.MEMSIZE(16), .ADDRESSSIZE(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_en_write(ram_en_write), .ram_en_read(ram_en_read),
        .ram_read_data(ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM: combinational read, write ignored while in reset
    logic [15:0] ram_mem [16];
    assign ram_read_data = ram_mem[ram_address];
    always @(posedge clk) begin
        if (!rst && ram_en_write) ram_mem[ram_address] <= ram_write_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: a grant occupies the arbiter for three cycles
    logic [15:0] mmem [16];
    logic [15:0] exp_rdata [2];
    logic [15:0] exp_wdata, rd_val;
    logic [3:0]  exp_addr, tx_addr;
    logic [15:0] tx_wdata;
    logic        tx_we, tx_id, pref;
    int k = 0, free_k = 0, serve_k = -10, ack_k = -10;

    always @(negedge clk) begin
        k++;
        if (rst) begin
            check("rst_ack0", 32'(ack0), 0);
            check("rst_ack1", 32'(ack1), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_en", 32'({ram_en_write, ram_en_read}), 0);
            check("rst_addr", 32'(ram_address), 0);
            check("rst_rdata", 32'({rdata0, rdata1}), 0);
            exp_addr = '0; exp_wdata = '0;
            exp_rdata[0] = '0; exp_rdata[1] = '0;
            pref = 1'b0; serve_k = -10; ack_k = -10; free_k = k + 1;
        end else begin
            if (k == serve_k) begin
                if (tx_we) mmem[tx_addr] = tx_wdata;
                else       rd_val = mmem[tx_addr];
            end
            if (k == ack_k && !tx_we) exp_rdata[tx_id] = rd_val;
            check("busy", 32'(busy), 32'(k == serve_k || k == ack_k));
            check("en_write", 32'(ram_en_write), 32'(k == serve_k && tx_we));
            check("en_read", 32'(ram_en_read), 32'(k == serve_k && !tx_we));
            check("ram_address", 32'(ram_address), 32'(exp_addr));
            check("ram_write_data", 32'(ram_write_data), 32'(exp_wdata));
            check("ack0", 32'(ack0), 32'(k == ack_k && !tx_id));
            check("ack1", 32'(ack1), 32'(k == ack_k && tx_id));
            check("rdata0", 32'(rdata0), 32'(exp_rdata[0]));
            check("rdata1", 32'(rdata1), 32'(exp_rdata[1]));
            if (k >= free_k && (req0 || req1)) begin
                tx_id    = (req0 && req1) ? pref : req1;
                pref     = !tx_id;
                tx_we    = tx_id ? we1 : we0;
                tx_addr  = tx_id ? addr1 : addr0;
                tx_wdata = tx_id ? wdata1 : wdata0;
                exp_addr = tx_addr; exp_wdata = tx_wdata;
                serve_k  = k + 1; ack_k = k + 2; free_k = k + 3;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // One transaction from requester id; reports ack latency, enable cycles, stray acks, read data
    task automatic do_txn(input int id, input logic we, input logic [3:0] a, input logic [15:0] d,
                          output int lat, output int en_cnt, output int other_ack,
                          output logic [15:0] rd);
        int  start;
        bit  got;
        lat = -1; en_cnt = 0; other_ack = 0; got = 0; rd = '0;
        if (id == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        else         begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        start = cyc;
        for (int n = 0; n < 12 && !got; n++) begin
            @(negedge clk);
            if (ram_en_write || ram_en_read) en_cnt++;
            if ((id == 0) ? ack1 : ack0) other_ack++;
            if ((id == 0) ? ack0 : ack1) begin
                got = 1;
                lat = cyc - start;
                rd  = (id == 0) ? rdata0 : rdata1;
            end
        end
        step();
        if (id == 0) req0 = 0; else req1 = 0;
    endtask

    task automatic wait_ack(input int id, output int c);
        c = -1;
        for (int n = 0; n < 12 && c < 0; n++) begin
            @(negedge clk);
            if ((id == 0) ? ack0 : ack1) c = cyc;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, en, oth, c0, c1, t0, n_ack;
        logic [15:0] rd;
        int ids [4];
        int cs  [4];

        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = 16'h1000 + 16'(i);
            mmem[i]    = 16'h1000 + 16'(i);
        end
        rst = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #1 rst = 1;
        step(); step(); step();
        rst = 0;
        step();

        // Write from requester 0
        do_txn(0, 1'b1, 4'd3, 16'hA5A5, lat, en, oth, rd);
        check("t1_latency", 32'(lat), 2);
        check("t1_en_cycles", 32'(en), 1);
        check("t1_ack1_seen", 32'(oth), 0);

        // Read back from requester 1
        do_txn(1, 1'b0, 4'd3, 16'h0000, lat, en, oth, rd);
        check("t2_rdata1", 32'(rd), 32'h0000A5A5);
        check("t2_latency", 32'(lat), 2);
        check("t2_en_cycles", 32'(en), 1);
        check("t2_rdata0_held", 32'(rdata0), 0);

        // Both requesting continuously from reset
        rst = 1;
        req0 = 1; we0 = 0; addr0 = 4'd1;
        req1 = 1; we1 = 0; addr1 = 4'd2;
        step(); step();
        rst = 0;
        for (int i = 0; i < 4; i++) begin ids[i] = -1; cs[i] = -100; end
        n_ack = 0;
        for (int n = 0; n < 20 && n_ack < 4; n++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                ids[n_ack] = ack1 ? 1 : 0;
                cs[n_ack]  = cyc;
                n_ack++;
            end
        end
        step();
        req0 = 0; req1 = 0;
        check("t3_ack_count", 32'(n_ack), 4);
        check("t3_grant0", 32'(ids[0]), 0);
        check("t3_grant1", 32'(ids[1]), 1);
        check("t3_grant2", 32'(ids[2]), 0);
        check("t3_grant3", 32'(ids[3]), 1);
        for (int i = 0; i < 3; i++) check("t3_spacing", 32'(cs[i+1] - cs[i]), 3);
        check("t3_rdata0", 32'(rdata0), 32'h00001001);
        check("t3_rdata1", 32'(rdata1), 32'h00001002);
        step();

        // Requester 1 arrives during requester 0's SERVE
        req0 = 1; we0 = 0; addr0 = 4'd4;
        t0 = cyc;
        step();
        req1 = 1; we1 = 1; addr1 = 4'd6; wdata1 = 16'h0606;
        wait_ack(0, c0);
        step();
        req0 = 0;
        wait_ack(1, c1);
        step();
        req1 = 0;
        check("t4_ack0_latency", 32'(c0 - t0), 2);
        check("t4_ack1_after_ack0", 32'(c1 - c0), 3);
        check("t4_rdata0", 32'(rdata0), 32'h00001004);

        // Top address, then untouched address 0, then read back the top address
        do_txn(1, 1'b1, 4'd15, 16'hFFFF, lat, en, oth, rd);
        do_txn(1, 1'b0, 4'd0, 16'h0000, lat, en, oth, rd);
        check("t5_addr0_unaffected", 32'(rd), 32'h00001000);
        do_txn(0, 1'b0, 4'd15, 16'h0000, lat, en, oth, rd);
        check("t5_rdata_ffff", 32'(rd), 32'h0000FFFF);

        // Reset pulsed during SERVE of a write
        req0 = 1; we0 = 1; addr0 = 4'd5; wdata0 = 16'h5555;
        step();
        rst = 1;
        step();
        rst = 0; req0 = 0;
        oth = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (ack0 || ack1) oth++;
        end
        check("t6_no_ack", 32'(oth), 0);
        check("t6_busy", 32'(busy), 0);
        step();
        req0 = 1; we0 = 0; addr0 = 4'd5;
        req1 = 1; we1 = 0; addr1 = 4'd7;
        wait_ack(0, c0);
        check("t6_rr_reset_first_is_0", 32'(c0 >= 0), 1);
        check("t6_write_dropped", 32'(rdata0), 32'h00001005);
        step();
        req0 = 0;
        wait_ack(1, c1);
        step();
        req1 = 0;
        check("t6_next_served", 32'(c1 - c0), 3);
        check("t6_rdata1", 32'(rdata1), 32'h00001007);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port `RAM` block. It lets two independent requesters (for example, a load/compute engine and a result-dump engine) share one RAM instance. It serialises their read and write transactions and drives the RAM's `address`, `writeData`, `enWrite` and `enRead` pins. It returns a registered read result and an acknowledge pulse to each requester.

## Interface
- `MEMSIZE`, 16, data word width; matches RAM `MEMSIZE`.
- `ADDRESSSIZE`, 4, address width; matches RAM `ADDRESSSIZE`.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0`, `req1`  in  1  request level from requester 0/1, held until ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; sampled with the request.
- `addr0`, `addr1`  in  ADDRESSSIZE  transaction address.
- `wdata0`, `wdata1`  in  MEMSIZE  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  MEMSIZE  read result; valid while ack is high, then held.
- `busy`  out  1  high in any non-IDLE state.
- `ram_address`  out  ADDRESSSIZE  to RAM `address`.
- `ram_write_data`  out  MEMSIZE  to RAM `writeData`.
- `ram_en_write`  out  1  to RAM `enWrite`.
- `ram_en_read`  out  1  to RAM `enRead`.
- `ram_read_data`  in  MEMSIZE  from RAM `readData`; combinational from the RAM.

## Operation
- FSM states: IDLE, SERVE, ACK.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester selected by the round-robin pointer `rr` (reset 0).
  - On grant: latch the granted requester's id, we, addr and wdata into internal registers, then go to SERVE.
- **SERVE** (exactly one cycle)
  - `ram_address` and `ram_write_data` are driven from the latched registers.
  - `ram_en_write` = latched we; `ram_en_read` = not latched we.
  - The RAM commits the write at the closing edge of SERVE.
  - For a read, `ram_read_data` is captured into `rdataN` of the granted requester at the same edge.
  - Next state: ACK.
- **ACK** (exactly one cycle)
  - `ackN` is high for the granted requester only.
  - `rr` is set to the other requester.
  - Next state: IDLE unconditionally. Requests are not sampled in ACK.
- Requester rules:
  - Keep `reqN` and its inputs stable from assertion until `ackN`.
  - A `reqN` still high in the IDLE cycle after ACK is treated as a new transaction (back-to-back access).
- `rdataN` of the non-granted requester and `rdataN` after a write are unchanged.
- RAM enables are 0, and `ram_address`/`ram_write_data` hold their last values, in IDLE and ACK.
- The block does not touch the RAM `readFile`/`writeFile` pins. The top level drives those only while `busy` = 0.

## Timing
- Reset values: state IDLE, `rr` = 0, `ack0` = `ack1` = 0, `rdata0` = `rdata1` = 0, `busy` = 0, `ram_en_write` = `ram_en_read` = 0, `ram_address` = 0, `ram_write_data` = 0.
- All outputs are registered, or decoded from registered state only. No combinational path exists from `reqN` to any output.
- Latency: with `req` sampled high in IDLE at edge E0, SERVE is E0..E1 and `ack` is high in E1..E2. `ack` therefore appears in the 2nd cycle after the sampling edge.
- Throughput: one transaction per 3 cycles. With both requesters continuously requesting, grants alternate 0, 1, 0, 1.
- Simultaneous requests: the `rr` owner wins. A lone request wins regardless of `rr`.
- A request that arrives during SERVE or ACK waits. It is first sampled in the next IDLE.
- Address wrap-around: not applicable. Any `ADDRESSSIZE`-bit value is passed through unchanged.
- Reset mid-operation:
  - Asserting `rst` in SERVE or ACK forces IDLE immediately and clears `ack`, the enables and `rr`.
  - An interrupted transaction is never acknowledged; the requester must re-request.
  - The RAM ignores writes while `rst` is high.

## Test plan
- Reset, then `req0` write, addr 3, data 0xA5A5 → `ram_en_write` high for one cycle, `ack0` pulses 2 cycles after sampling, `ack1` stays 0.
- `req1` read, addr 3 after the previous write → `ram_en_read` high in SERVE, `rdata1` = 0xA5A5 with `ack1`, `rdata0` unchanged.
- `req0` and `req1` both high from reset, held continuously → grant order 0, 1, 0, 1, with acks spaced 3 cycles apart.
- `req1` raised during requester 0's SERVE cycle → `req1` is served in the following IDLE, and `ack1` arrives 3 cycles after `ack0`.
- Write 0xFFFF to addr 15, then read addr 15 → `rdata` = 0xFFFF; addr 0 is unaffected (read back = prior value).
- `rst` pulsed during SERVE of a write → no ack, `busy` = 0, `rr` = 0, and the next request is served normally.
